// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU command issuer.
// The tagged command layout is selected by ALU_ISSUE_TAG_EN.
package alu_pkg;

  localparam int ALU_W     = 32;
  localparam int ALU_TAG_W = 4;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_AND  = 3'b010;
  localparam logic [2:0] OP_OR   = 3'b011;
  localparam logic [2:0] OP_XOR  = 3'b100;
  localparam logic [2:0] OP_SHL  = 3'b101;
  localparam logic [2:0] OP_NOT  = 3'b110;
  localparam logic [2:0] OP_PASS = 3'b111;

  typedef enum logic [1:0] {IDLE, WAIT, HOLD} state_t;

  typedef struct packed {
    logic [2:0]       op;
    logic [ALU_W-1:0] a;
    logic [ALU_W-1:0] b;
`ifdef ALU_ISSUE_TAG_EN
    logic [ALU_TAG_W-1:0] tag;
`endif
  } cmd_t;

endpackage

// File: rtl/alu_cmd_fifo.sv
// Synchronous command FIFO with a registered occupancy count.
// No pop-through: a full FIFO refuses pushes even when popping in the same edge.
module alu_cmd_fifo #(
  parameter int DEPTH   = 4,
  parameter int ENTRY_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               push,
  input  logic               pop,
  input  logic [ENTRY_W-1:0] din,
  output logic [ENTRY_W-1:0] dout,
  output logic               full,
  output logic               empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [ENTRY_W-1:0] mem [DEPTH];
  logic [AW-1:0]      wptr;
  logic [AW-1:0]      rptr;
  logic [AW:0]        count;
  logic               do_push;
  logic               do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign dout    = mem[rptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= din;
  end

endmodule

// File: rtl/alu_cmd_issuer.sv
// Feeds a registered ALU one command at a time from a FIFO and returns results
// on a valid/ready port. Optional sequence tags: define ALU_ISSUE_TAG_EN.
module alu_cmd_issuer
  import alu_pkg::*;
#(
  parameter int W       = ALU_W,
  parameter int DEPTH   = 4,
  parameter int ALU_LAT = 1,
  parameter int TAG_W   = ALU_TAG_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [2:0]   in_op,
  input  logic [W-1:0] in_a,
  input  logic [W-1:0] in_b,
  output logic [2:0]   alu_op,
  output logic [W-1:0] alu_a,
  output logic [W-1:0] alu_b,
  input  logic [W-1:0] alu_o,
  output logic         res_valid,
  input  logic         res_ready,
  output logic [W-1:0] res_data,
  output logic [2:0]   res_op
`ifdef ALU_ISSUE_TAG_EN
  ,
  output logic [TAG_W-1:0] res_tag
`endif
);

  localparam int CNT_W = $clog2(ALU_LAT + 1);
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(ALU_LAT);

  if (W != ALU_W) begin : g_width_check
    $error("alu_cmd_issuer: W must equal alu_pkg::ALU_W");
  end

  cmd_t             cmd_in;
  cmd_t             head;
  logic             fifo_full;
  logic             fifo_empty;
  logic             push;
  logic             pop;
  state_t           state;
  logic [CNT_W-1:0] cnt;

  assign in_ready = !fifo_full;
  assign push     = in_valid && !fifo_full;
  // Every pop is an issue: from IDLE, or from HOLD on the result handshake.
  assign pop      = !fifo_empty && ((state == IDLE) || (state == HOLD && res_ready));

`ifdef ALU_ISSUE_TAG_EN
  logic [TAG_W-1:0] tag_cnt;
  logic [TAG_W-1:0] tag_p0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) tag_cnt <= '0;
    else if (push) tag_cnt <= tag_cnt + 1'b1;
  end

  assign cmd_in = '{op: in_op, a: in_a, b: in_b, tag: tag_cnt};
`else
  assign cmd_in = '{op: in_op, a: in_a, b: in_b};
`endif

  alu_cmd_fifo #(
    .DEPTH  (DEPTH),
    .ENTRY_W($bits(cmd_t))
  ) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (push),
    .pop  (pop),
    .din  (cmd_in),
    .dout (head),
    .full (fifo_full),
    .empty(fifo_empty)
  );

  // Issue stage: ALU inputs change only on an issue edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_op <= '0;
      alu_a  <= '0;
      alu_b  <= '0;
`ifdef ALU_ISSUE_TAG_EN
      tag_p0 <= '0;
`endif
    end else if (pop) begin
      alu_op <= head.op;
      alu_a  <= head.a;
      alu_b  <= head.b;
`ifdef ALU_ISSUE_TAG_EN
      tag_p0 <= head.tag;
`endif
    end
  end

  // Sequencing and result capture stage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      res_valid <= 1'b0;
      res_data  <= '0;
      res_op    <= '0;
`ifdef ALU_ISSUE_TAG_EN
      res_tag   <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (pop) begin
            cnt   <= CNT_INIT;
            state <= WAIT;
          end
        end
        WAIT: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else begin
            res_data  <= alu_o;
            res_op    <= alu_op;
`ifdef ALU_ISSUE_TAG_EN
            res_tag   <= tag_p0;
`endif
            res_valid <= 1'b1;
            state     <= HOLD;
          end
        end
        HOLD: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            if (pop) begin
              cnt   <= CNT_INIT;
              state <= WAIT;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_cmd_issuer.sv
// Bench for alu_cmd_issuer with a behavioural registered ALU and a queue scoreboard.
// Tag checks are compiled in when ALU_ISSUE_TAG_EN is defined.
module tb_alu_cmd_issuer;

  localparam int W     = 32;
  localparam int TAG_W = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [2:0]   in_op = '0;
  logic [W-1:0] in_a = '0;
  logic [W-1:0] in_b = '0;
  logic [2:0]   alu_op;
  logic [W-1:0] alu_a;
  logic [W-1:0] alu_b;
  logic [W-1:0] alu_o = '0;
  logic         res_valid;
  logic         res_ready = 1'b0;
  logic [W-1:0] res_data;
  logic [2:0]   res_op;
`ifdef ALU_ISSUE_TAG_EN
  logic [TAG_W-1:0] res_tag;
`endif

  alu_cmd_issuer #(.W(W), .DEPTH(4), .ALU_LAT(1), .TAG_W(TAG_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_op    (in_op),
    .in_a     (in_a),
    .in_b     (in_b),
    .alu_op   (alu_op),
    .alu_a    (alu_a),
    .alu_b    (alu_b),
    .alu_o    (alu_o),
    .res_valid(res_valid),
    .res_ready(res_ready),
    .res_data (res_data),
    .res_op   (res_op)
`ifdef ALU_ISSUE_TAG_EN
    ,
    .res_tag  (res_tag)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] alu_ref(input logic [2:0] op, input logic [W-1:0] a,
                                           input logic [W-1:0] b);
    case (op)
      3'b000:  return a + b;
      3'b001:  return a - b;
      3'b010:  return a & b;
      3'b011:  return a | b;
      3'b100:  return a ^ b;
      3'b101:  return a << b[4:0];
      3'b110:  return ~a;
      default: return a;
    endcase
  endfunction

  // Registered ALU: O follows the inputs one clock edge later.
  always @(posedge clk) alu_o <= alu_ref(alu_op, alu_a, alu_b);

  int n_vec = 0;
  int n_mis = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [2:0]   op;
    logic [W-1:0] data;
    int           tag;
  } exp_t;

  exp_t q[$];
  int   mdl_tag = 0;
  logic stalled = 1'b0;
  logic [W-1:0] sv_data, sv_a, sv_b;
  logic [2:0]   sv_op, sv_aop;

  // Monitor: record accepted commands, check results and stall stability.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      q.delete();
      mdl_tag = 0;
      stalled = 1'b0;
    end else begin
      if (stalled) begin
        chk("stall_valid", 32'(res_valid), 32'd1);
        chk("stall_data", res_data, sv_data);
        chk("stall_op", 32'(res_op), 32'(sv_op));
        chk("stall_alu_a", alu_a, sv_a);
        chk("stall_alu_b", alu_b, sv_b);
        chk("stall_alu_op", 32'(alu_op), 32'(sv_aop));
      end
      if (in_valid && in_ready) begin
        e.op   = in_op;
        e.data = alu_ref(in_op, in_a, in_b);
        e.tag  = mdl_tag;
        mdl_tag = (mdl_tag + 1) % (1 << TAG_W);
        q.push_back(e);
      end
      if (res_valid && res_ready) begin
        if (q.size() == 0) begin
          chk("unexpected_result", res_data, 32'hxxxxxxxx);
        end else begin
          e = q.pop_front();
          chk("res_data", res_data, e.data);
          chk("res_op", 32'(res_op), 32'(e.op));
`ifdef ALU_ISSUE_TAG_EN
          chk("res_tag", 32'(res_tag), 32'(e.tag));
`endif
        end
      end
      stalled = res_valid && !res_ready;
      sv_data = res_data;
      sv_op   = res_op;
      sv_a    = alu_a;
      sv_b    = alu_b;
      sv_aop  = alu_op;
    end
  end

  task automatic send(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    int   guard;
    logic acc;
    guard    = 0;
    in_valid = 1'b1;
    in_op    = op;
    in_a     = a;
    in_b     = b;
    forever begin
      acc = in_ready;
      @(posedge clk);
      #1;
      if (acc) break;
      guard++;
      if (guard > 1000) begin
        chk("send_timeout", 32'(acc), 32'd1);
        break;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic drain;
    int guard;
    guard = 0;
    while (q.size() != 0 || res_valid) begin
      @(posedge clk);
      #1;
      guard++;
      if (guard > 2000) begin
        chk("drain_timeout", 32'(q.size()), 32'd0);
        break;
      end
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  logic done_rnd = 1'b0;

  initial begin
    int k;
    // Reset state
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_res_valid", 32'(res_valid), 32'd0);
    chk("rst_res_data", res_data, 32'd0);
    chk("rst_alu_a", alu_a, 32'd0);
    chk("rst_alu_op", 32'(alu_op), 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Single NOT: result visible three edges after the push edge
    res_ready = 1'b1;
    in_valid  = 1'b1;
    in_op     = 3'b110;
    in_a      = 32'hCD0AD074;
    in_b      = $urandom;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    k = 0;
    for (int i = 1; i <= 8; i++) begin
      @(posedge clk);
      #1;
      if (res_valid) begin
        k = i;
        break;
      end
    end
    chk("not_latency", 32'(k), 32'd3);
    chk("not_data", res_data, 32'h32F52F8B);
    chk("not_op", 32'(res_op), 32'd6);
    drain();

    // Back-to-back NOTs
    send(3'b110, 32'h34EB5103, $urandom);
    send(3'b110, 32'h55174CA3, $urandom);
    drain();

    // Backpressure: one in flight plus four queued fills the FIFO
    res_ready = 1'b0;
    for (int i = 0; i < 5; i++) send(3'($urandom_range(0, 7)), $urandom, $urandom);
    chk("full_in_ready", 32'(in_ready), 32'd0);
    in_valid = 1'b1;
    in_op    = 3'b000;
    repeat (3) @(posedge clk);
    #1;
    chk("full_still_blocked", 32'(in_ready), 32'd0);
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    chk("stall_res_valid", 32'(res_valid), 32'd1);
    chk("stall_queue_depth", 32'(q.size()), 32'd5);
    res_ready = 1'b1;
    drain();

    // Reset while a command is in WAIT with three queued
    res_ready = 1'b0;
    for (int i = 0; i < 5; i++) send(3'($urandom_range(0, 7)), $urandom, $urandom);
    res_ready = 1'b1;
    @(posedge clk);
    #1;
    res_ready = 1'b0;
    rst = 1'b1;
    #1;
    chk("midrst_res_valid", 32'(res_valid), 32'd0);
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    res_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("post_rst_no_result", 32'(res_valid), 32'd0);
    end
    @(posedge clk);
    #1;

    // Randomized traffic with random backpressure
    fork
      begin
        for (int i = 0; i < 200; i++) begin
          send(3'($urandom_range(0, 7)), $urandom, $urandom);
          repeat ($urandom_range(0, 2)) @(posedge clk);
          #0;
        end
        done_rnd = 1'b1;
      end
      begin
        while (!done_rnd) begin
          @(posedge clk);
          #1;
          res_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    res_ready = 1'b1;
    drain();

`ifdef ALU_ISSUE_TAG_EN
    // Tag sequence restarts from zero after reset and wraps
    do_reset();
    for (int i = 0; i < 18; i++) send(3'($urandom_range(0, 7)), $urandom, $urandom);
    drain();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
